// File: rtl/blackjack_pkg.sv
// Shared hand-state encoding and card/score constants for the blackjack hand receiver.
package blackjack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_BUST,
        ST_BLACKJACK,
        ST_STOOD
    } hand_state_t;

    localparam int CARD_ACE   = 1;
    localparam int CARD_MAX   = 10;
    localparam int BUST_LIMIT = 21;
    localparam int SOFT_BONUS = 10;

endpackage

// File: rtl/hand_score_calc.sv
// Combinational best-score and bust evaluation from the hard total and the sticky ace flag.
// Soft-ace scoring is enabled by defining HAND_SOFT_ACE_EN.
module hand_score_calc
    import blackjack_pkg::*;
#(
    parameter int SCORE_W = 5
) (
    input  logic [SCORE_W-1:0] hard,
    input  logic               has_ace,
    output logic [SCORE_W-1:0] hand_total,
    output logic               is_bust
);

`ifdef HAND_SOFT_ACE_EN
    logic [SCORE_W:0] soft_sum;

    // One extra bit so hard totals near the top of the range cannot wrap into a false soft hand.
    assign soft_sum   = {1'b0, hard} + (SCORE_W+1)'(SOFT_BONUS);
    assign hand_total = (has_ace && (soft_sum <= (SCORE_W+1)'(BUST_LIMIT)))
                        ? soft_sum[SCORE_W-1:0] : hard;
`else
    logic unused_ace;

    assign unused_ace = has_ace;
    assign hand_total = hard;
`endif

    assign is_bust = (hard > SCORE_W'(BUST_LIMIT));

endmodule

// File: rtl/blackjack_hand_receiver.sv
// Accepts dealt cards over valid/ready and accumulates one hand's score, count and status.
// Defining HAND_SOFT_ACE_EN enables soft aces and the BLACKJACK outcome.
module blackjack_hand_receiver
    import blackjack_pkg::*;
#(
    parameter int MAX_CARDS = 8,
    parameter int CARD_W    = 5,
    parameter int SCORE_W   = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               card_valid,
    input  logic [CARD_W-1:0]  card_value,
    output logic               card_ready,
    input  logic               stand,
    input  logic               new_hand,
    output logic [SCORE_W-1:0] hand_total,
    output logic [3:0]         card_count,
    output logic               bust,
    output logic               blackjack,
    output logic               stood,
    output logic               card_err
);

    hand_state_t        state;
    logic [SCORE_W-1:0] hard_q;
    logic               has_ace_q;
    logic               card_legal;
    logic [SCORE_W-1:0] next_hard;
    logic               next_ace;
    logic [3:0]         next_count;
    logic [SCORE_W-1:0] next_total;
    logic               next_bust;

    assign card_ready = (state == ST_IDLE) || (state == ST_DRAW);
    assign card_legal = (card_value >= CARD_W'(CARD_ACE)) && (card_value <= CARD_W'(CARD_MAX));

    // Score the hand as it would be with the offered card, so the outcome lands on the transfer edge.
    assign next_hard  = hard_q + SCORE_W'(card_value);
    assign next_ace   = has_ace_q || (card_value == CARD_W'(CARD_ACE));
    assign next_count = (card_count == 4'(MAX_CARDS)) ? card_count : card_count + 4'd1;

    hand_score_calc #(
        .SCORE_W (SCORE_W)
    ) u_score (
        .hard       (next_hard),
        .has_ace    (next_ace),
        .hand_total (next_total),
        .is_bust    (next_bust)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            hard_q     <= '0;
            has_ace_q  <= 1'b0;
            hand_total <= '0;
            card_count <= '0;
            card_err   <= 1'b0;
        end else begin
            card_err <= 1'b0;
            if (new_hand) begin
                state      <= ST_IDLE;
                hard_q     <= '0;
                has_ace_q  <= 1'b0;
                hand_total <= '0;
                card_count <= '0;
            end else if (stand && card_ready) begin
                state <= ST_STOOD;
            end else if (card_valid && card_ready) begin
                if (!card_legal) begin
                    card_err <= 1'b1;
                end else begin
                    hard_q     <= next_hard;
                    has_ace_q  <= next_ace;
                    hand_total <= next_total;
                    card_count <= next_count;
                    if (next_bust) begin
                        state <= ST_BUST;
`ifdef HAND_SOFT_ACE_EN
                    end else if ((next_count == 4'd2) && (next_total == SCORE_W'(BUST_LIMIT))) begin
                        state <= ST_BLACKJACK;
`endif
                    end else if (next_count == 4'(MAX_CARDS)) begin
                        state <= ST_STOOD;
                    end else begin
                        state <= ST_DRAW;
                    end
                end
            end
        end
    end

    assign bust  = (state == ST_BUST);
    assign stood = (state == ST_STOOD);
`ifdef HAND_SOFT_ACE_EN
    assign blackjack = (state == ST_BLACKJACK);
`else
    assign blackjack = 1'b0;
`endif

endmodule

// File: tb/tb_blackjack_hand_receiver.sv
// Directed-vector bench for blackjack_hand_receiver; expectations follow HAND_SOFT_ACE_EN when defined.
module tb_blackjack_hand_receiver;

    logic       clock;
    logic       reset_n;
    logic       card_valid;
    logic [4:0] card_value;
    logic       card_ready;
    logic       stand;
    logic       new_hand;
    logic [4:0] hand_total;
    logic [3:0] card_count;
    logic       bust;
    logic       blackjack;
    logic       stood;
    logic       card_err;

    int vectors;
    int miscompares;

    blackjack_hand_receiver #(
        .MAX_CARDS (8),
        .CARD_W    (5),
        .SCORE_W   (5)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .card_valid (card_valid),
        .card_value (card_value),
        .card_ready (card_ready),
        .stand      (stand),
        .new_hand   (new_hand),
        .hand_total (hand_total),
        .card_count (card_count),
        .bust       (bust),
        .blackjack  (blackjack),
        .stood      (stood),
        .card_err   (card_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic deal(input logic [4:0] v);
        card_valid = 1'b1;
        card_value = v;
        tick();
        card_valid = 1'b0;
    endtask

    task automatic start_hand();
        new_hand = 1'b1;
        tick();
        new_hand = 1'b0;
    endtask

    task automatic check_hand(input string tag, input int total, input int count,
                              input logic rdy, input logic bst, input logic bj, input logic std);
        check_val({tag, "_total"}, 32'(hand_total), 32'(total));
        check_val({tag, "_count"}, 32'(card_count), 32'(count));
        check_val({tag, "_ready"}, 32'(card_ready), 32'(rdy));
        check_val({tag, "_bust"},  32'(bust),       32'(bst));
        check_val({tag, "_bj"},    32'(blackjack),  32'(bj));
        check_val({tag, "_stood"}, 32'(stood),      32'(std));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        card_valid  = 1'b0;
        card_value  = '0;
        stand       = 1'b0;
        new_hand    = 1'b0;
        #12;
        check_hand("reset", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("reset_err", 32'(card_err), 32'd0);
        reset_n = 1'b1;
        tick();

        // 10, 7, stand
        deal(5'd10);
        deal(5'd7);
        check_hand("t1_draw", 17, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        stand = 1'b1;
        tick();
        stand = 1'b0;
        check_hand("t1_stood", 17, 2, 1'b0, 1'b0, 1'b0, 1'b1);
        start_hand();
        check_hand("t1_new", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // ace + ten
        deal(5'd1);
        deal(5'd10);
`ifdef HAND_SOFT_ACE_EN
        check_hand("t2_bj", 21, 2, 1'b0, 1'b0, 1'b1, 1'b0);
`else
        check_hand("t2_hard", 11, 2, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        start_hand();

        // 10, 6, 9 busts; later offers ignored
        deal(5'd10);
        deal(5'd6);
        deal(5'd9);
        check_hand("t3_bust", 25, 3, 1'b0, 1'b1, 1'b0, 1'b0);
        card_valid = 1'b1;
        card_value = 5'd5;
        tick();
        tick();
        card_valid = 1'b0;
        check_hand("t3_hold", 25, 3, 1'b0, 1'b1, 1'b0, 1'b0);
        start_hand();

        // 1, 5, 9: soft 16 demotes to hard 15
        deal(5'd1);
        deal(5'd5);
`ifdef HAND_SOFT_ACE_EN
        check_val("t4_soft16", 32'(hand_total), 32'd16);
`else
        check_val("t4_hard6", 32'(hand_total), 32'd6);
`endif
        deal(5'd9);
        check_hand("t4_demote", 15, 3, 1'b1, 1'b0, 1'b0, 1'b0);

        // illegal ranks in DRAW
        deal(5'd0);
        check_val("t5_err0", 32'(card_err), 32'd1);
        check_hand("t5_keep0", 15, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("t5_pulse0", 32'(card_err), 32'd0);
        deal(5'd12);
        check_val("t5_err12", 32'(card_err), 32'd1);
        check_val("t5_keep12", 32'(hand_total), 32'd15);
        tick();
        check_val("t5_pulse12", 32'(card_err), 32'd0);

        // new_hand wins over a card on the same edge
        card_valid = 1'b1;
        card_value = 5'd4;
        new_hand   = 1'b1;
        tick();
        card_valid = 1'b0;
        new_hand   = 1'b0;
        check_hand("t6_new", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("t6_err", 32'(card_err), 32'd0);

        // asynchronous reset mid-DRAW, checked before the next edge
        deal(5'd3);
        deal(5'd4);
        check_hand("t6_draw", 7, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        check_hand("t6_rst", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        reset_n = 1'b1;
        tick();

        // stand from IDLE
        stand = 1'b1;
        tick();
        stand = 1'b0;
        check_hand("idle_stand", 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        start_hand();

        // card and stand together in DRAW: card dropped
        deal(5'd5);
        card_valid = 1'b1;
        card_value = 5'd6;
        stand      = 1'b1;
        tick();
        card_valid = 1'b0;
        stand      = 1'b0;
        check_hand("card_stand", 5, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        start_hand();

        // eight 2s force STOOD at MAX_CARDS
        for (int i = 0; i < 7; i++) deal(5'd2);
        check_hand("t7_seven", 14, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        deal(5'd2);
        check_hand("t7_max", 16, 8, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
